// File: rtl/df_pkg.sv
// Shared dataflow package: sink FSM states and default token/FIFO/counter sizes.
package df_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FIN     = 2'd2
    } df_state_e;

    localparam int DF_N     = 16;
    localparam int DF_DEPTH = 16;
    localparam int DF_CW    = 16;

endpackage

// File: rtl/df_sync_fifo.sv
// Single-clock FIFO with registered read port; a push is accepted at full
// when a pop is taken in the same cycle, and a pop of an empty FIFO is ignored.
module df_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic          push_ok_o,
    output logic          pop_ok_o,
    output logic [W-1:0]  rdata_o,
    output logic          rvalid_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   level_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] rdata_q;
    logic         rvalid_q;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign empty_o   = (level_o == '0);
    assign full_o    = (level_o == (AW+1)'(DEPTH));
    assign pop_ok_o  = pop_i & ~empty_o;
    assign push_ok_o = push_i & (~full_o | pop_ok_o);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok_o) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok_o)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rvalid_q <= pop_ok_o;
            if (pop_ok_o) rdata_q <= mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/df_sink.sv
// Dataflow result sink: collects R/D tokens into a FIFO until TOTAL are accepted.
// Optional macro DF_SINK_DROP_CNT_EN adds the saturating DROPS counter output.
module df_sink
    import df_pkg::*;
#(
    parameter int N     = DF_N,
    parameter int DEPTH = DF_DEPTH,
    parameter int CW    = DF_CW
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     R_IN,
    input  logic [N-1:0]             D_IN,
    input  logic                     START,
    input  logic [CW-1:0]            TOTAL,
    input  logic                     RD_EN,
    output logic [N-1:0]             RD_DATA,
    output logic                     RD_VALID,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     DONE,
    output logic                     OVERFLOW,
`ifdef DF_SINK_DROP_CNT_EN
    output logic [CW-1:0]            DROPS,
`endif
    output df_state_e                STATE
);

    df_state_e     state_q, state_d;
    logic [CW-1:0] total_q, total_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          token, accept, drop, pop_ok, arm;

    assign token = EN & R_IN & (state_q == COLLECT);
    assign drop  = token & ~accept;
    assign arm   = START & (state_q != COLLECT);

    df_sync_fifo #(.W(N), .DEPTH(DEPTH)) u_fifo (
        .clk_i     (CLK),
        .rst_i     (RST),
        .push_i    (token),
        .wdata_i   (D_IN),
        .pop_i     (RD_EN),
        .push_ok_o (accept),
        .pop_ok_o  (pop_ok),
        .rdata_o   (RD_DATA),
        .rvalid_o  (RD_VALID),
        .empty_o   (EMPTY),
        .full_o    (FULL),
        .level_o   (LEVEL)
    );

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    count_d = count_q + CW'(1);
                    if (count_d == total_q) state_d = FIN;
                end
                if (drop) ovf_d = 1'b1;
            end
            default: begin
                // IDLE and FIN arm identically; FIFO contents are retained.
                if (arm) begin
                    total_d = TOTAL;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = (TOTAL == '0) ? FIN : COLLECT;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            total_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef DF_SINK_DROP_CNT_EN
    logic [CW-1:0] drops_q;

    always_ff @(posedge CLK) begin
        if (RST || arm)                drops_q <= '0;
        else if (drop && drops_q != '1) drops_q <= drops_q + CW'(1);
    end

    assign DROPS = drops_q;
`endif

    assign DONE     = (state_q == FIN);
    assign OVERFLOW = ovf_q;
    assign STATE    = state_q;

    logic unused_ok;
    assign unused_ok = pop_ok;

endmodule
